// File: rtl/stream_demux.sv
// -----------------------------------------------------------------------------
// stream_demux
//   Registered 1-to-NUM_OUT stream demultiplexer. One input beat is captured
//   into a single holding register and presented on exactly one output
//   channel the cycle after acceptance. The destination comes from s_sel
//   (directed mode) or from an internal round-robin pointer (round-robin mode).
//
// Ports:
//   clk      rising-edge clock
//   rst_n    synchronous active-low reset
//   mode     0 = directed (s_sel), 1 = round-robin (rr_ptr)
//   s_valid  input beat valid
//   s_ready  input beat accepted when s_valid && s_ready
//   s_data   input data
//   s_sel    destination channel in directed mode
//   m_valid  per-channel valid, at most one bit set
//   m_ready  per-channel ready
//   m_data   channel k at bits [k*DATA_W +: DATA_W], zero when not valid
//   err_sel  one-cycle pulse after an out-of-range s_sel beat was dropped
//   rr_ptr   next round-robin destination
// -----------------------------------------------------------------------------
module stream_demux #(
  parameter int DATA_W  = 8,
  parameter int NUM_OUT = 8,
  parameter int SEL_W   = $clog2(NUM_OUT)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      mode,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [DATA_W-1:0]         s_data,
  input  logic [SEL_W-1:0]          s_sel,
  output logic [NUM_OUT-1:0]        m_valid,
  input  logic [NUM_OUT-1:0]        m_ready,
  output logic [NUM_OUT*DATA_W-1:0] m_data,
  output logic                      err_sel,
  output logic [SEL_W-1:0]          rr_ptr
);

  localparam logic [SEL_W-1:0] LP_LAST = SEL_W'(NUM_OUT - 1);

  logic              r_hold_valid;
  logic [SEL_W-1:0]  r_hold_dst;
  logic [DATA_W-1:0] r_hold_data;
  logic [SEL_W-1:0]  r_rr_ptr;
  logic              r_err_sel;

  logic [NUM_OUT-1:0] w_hold_onehot;
  logic               w_dst_ready;
  logic               w_retire;
  logic               w_accept;
  logic [SEL_W-1:0]   w_dst;
  logic               w_sel_ok;
  logic               w_dst_ok;
  logic               w_hold_valid_nxt;
  logic [SEL_W-1:0]   w_hold_dst_nxt;
  logic [DATA_W-1:0]  w_hold_data_nxt;
  logic [SEL_W-1:0]   w_rr_ptr_nxt;
  logic               w_err_sel_nxt;

  // Out-of-range selects can only exist when NUM_OUT is not a power of two.
  if ((1 << SEL_W) == NUM_OUT) begin : g_pow2
    assign w_sel_ok = 1'b1;
  end else begin : g_npow2
    assign w_sel_ok = (s_sel <= LP_LAST);
  end

  // Decode the held destination and drive the per-channel outputs.
  always_comb begin
    w_hold_onehot = {NUM_OUT{1'b0}};
    m_data        = {(NUM_OUT*DATA_W){1'b0}};
    for (int k = 0; k < NUM_OUT; k++) begin
      w_hold_onehot[k] = (r_hold_dst == SEL_W'(k));
    end
    m_valid = {NUM_OUT{r_hold_valid}} & w_hold_onehot;
    for (int k = 0; k < NUM_OUT; k++) begin
      m_data[k*DATA_W +: DATA_W] = m_valid[k] ? r_hold_data : {DATA_W{1'b0}};
    end
  end

  // Only the selected channel's ready matters; others are masked off.
  assign w_dst_ready = |(m_ready & w_hold_onehot);
  assign w_retire    = r_hold_valid && w_dst_ready;
  assign s_ready     = rst_n && (!r_hold_valid || w_dst_ready);
  assign w_accept    = s_valid && s_ready;
  assign w_dst       = mode ? r_rr_ptr : s_sel;
  // rr_ptr never leaves range, so only directed beats can be dropped.
  assign w_dst_ok    = mode || w_sel_ok;

  // Next-state for the holding register, round-robin pointer and error pulse.
  always_comb begin
    w_hold_valid_nxt = r_hold_valid;
    w_hold_dst_nxt   = r_hold_dst;
    w_hold_data_nxt  = r_hold_data;
    w_rr_ptr_nxt     = r_rr_ptr;
    w_err_sel_nxt    = w_accept && !w_dst_ok;
    if (w_accept && w_dst_ok) begin
      w_hold_valid_nxt = 1'b1;
      w_hold_dst_nxt   = w_dst;
      w_hold_data_nxt  = s_data;
    end else if (w_retire || w_accept) begin
      // An accept implies any held beat retires this cycle, so a dropped
      // beat leaves the register empty as well.
      w_hold_valid_nxt = 1'b0;
    end else begin
      w_hold_valid_nxt = r_hold_valid;
    end
    if (w_accept && mode) begin
      w_rr_ptr_nxt = (r_rr_ptr == LP_LAST) ? {SEL_W{1'b0}} : r_rr_ptr + {{(SEL_W-1){1'b0}}, 1'b1};
    end else begin
      w_rr_ptr_nxt = r_rr_ptr;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hold_valid <= 1'b0;
      r_hold_dst   <= {SEL_W{1'b0}};
      r_hold_data  <= {DATA_W{1'b0}};
      r_rr_ptr     <= {SEL_W{1'b0}};
      r_err_sel    <= 1'b0;
    end else begin
      r_hold_valid <= w_hold_valid_nxt;
      r_hold_dst   <= w_hold_dst_nxt;
      r_hold_data  <= w_hold_data_nxt;
      r_rr_ptr     <= w_rr_ptr_nxt;
      r_err_sel    <= w_err_sel_nxt;
    end
  end

  assign err_sel = r_err_sel;
  assign rr_ptr  = r_rr_ptr;

endmodule

// File: tb/tb_stream_demux.sv
// -----------------------------------------------------------------------------
// tb_stream_demux
//   Drives an 8-channel and a 6-channel stream_demux. Expected beats are
//   pushed into per-instance queues at acceptance; monitors compare every
//   presented beat against the queue head and pop on handshake.
// -----------------------------------------------------------------------------
module tb_stream_demux;

  typedef struct packed {
    logic [2:0] dst;
    logic [7:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  logic        mode8, s_valid8, s_ready8, err_sel8;
  logic [7:0]  s_data8;
  logic [2:0]  s_sel8, rr_ptr8;
  logic [7:0]  m_valid8, m_ready8;
  logic [63:0] m_data8;

  logic        mode6, s_valid6, s_ready6, err_sel6;
  logic [7:0]  s_data6;
  logic [2:0]  s_sel6, rr_ptr6;
  logic [5:0]  m_valid6, m_ready6;
  logic [47:0] m_data6;

  exp_t q8[$];
  exp_t q6[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  logic [2:0] tb_rr = 3'd0;

  stream_demux #(.DATA_W(8), .NUM_OUT(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .mode(mode8), .s_valid(s_valid8), .s_ready(s_ready8),
    .s_data(s_data8), .s_sel(s_sel8), .m_valid(m_valid8), .m_ready(m_ready8),
    .m_data(m_data8), .err_sel(err_sel8), .rr_ptr(rr_ptr8)
  );

  stream_demux #(.DATA_W(8), .NUM_OUT(6)) u_dut6 (
    .clk(clk), .rst_n(rst_n), .mode(mode6), .s_valid(s_valid6), .s_ready(s_ready6),
    .s_data(s_data6), .s_sel(s_sel6), .m_valid(m_valid6), .m_ready(m_ready6),
    .m_data(m_data6), .err_sel(err_sel6), .rr_ptr(rr_ptr6)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor for the 8-channel instance.
  always @(negedge clk) begin : mon8
    exp_t        e;
    logic [7:0]  ev;
    logic [63:0] ed;
    if (|m_valid8) begin
      if (q8.size() == 0) begin
        chk("unexpected_beat8", {56'd0, m_valid8}, 64'd0);
      end else begin
        e  = q8[0];
        ev = 8'd1 << e.dst;
        ed = 64'd0;
        ed[int'(e.dst)*8 +: 8] = e.data;
        chk("m_valid8", {56'd0, m_valid8}, {56'd0, ev});
        chk("m_data8", m_data8, ed);
        if ((m_ready8 & m_valid8) != 8'd0) void'(q8.pop_front());
      end
    end
  end

  // Monitor for the 6-channel instance.
  always @(negedge clk) begin : mon6
    exp_t        e;
    logic [5:0]  ev;
    logic [47:0] ed;
    if (|m_valid6) begin
      if (q6.size() == 0) begin
        chk("unexpected_beat6", {58'd0, m_valid6}, 64'd0);
      end else begin
        e  = q6[0];
        ev = 6'd1 << e.dst;
        ed = 48'd0;
        ed[int'(e.dst)*8 +: 8] = e.data;
        chk("m_valid6", {58'd0, m_valid6}, {58'd0, ev});
        chk("m_data6", {16'd0, m_data6}, {16'd0, ed});
        if ((m_ready6 & m_valid6) != 6'd0) void'(q6.pop_front());
      end
    end
  end

  // Offer one beat to the 8-channel DUT; called just after a rising edge.
  task automatic send8(input logic [2:0] sel, input logic [7:0] data, input logic md,
                       output int stalls);
    int   n;
    exp_t e;
    n = 0;
    s_valid8 = 1'b1; s_sel8 = sel; s_data8 = data; mode8 = md;
    @(negedge clk);
    while (!s_ready8 && n < 50) begin
      @(negedge clk);
      n++;
    end
    stalls = n;
    if (!s_ready8) begin
      chk("accept_timeout8", 64'd0, 64'd1);
    end else begin
      e.dst  = md ? tb_rr : sel;
      e.data = data;
      q8.push_back(e);
      if (md) tb_rr = (tb_rr == 3'd7) ? 3'd0 : tb_rr + 3'd1;
    end
    @(posedge clk); #1;
    s_valid8 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int st;
    int c0;
    int stall_sum;
    rst_n = 1'b0;
    mode8 = 1'b0; s_valid8 = 1'b0; s_data8 = 8'd0; s_sel8 = 3'd0; m_ready8 = 8'hFF;
    mode6 = 1'b0; s_valid6 = 1'b0; s_data6 = 8'd0; s_sel6 = 3'd0; m_ready6 = 6'h3F;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_s_ready", {63'd0, s_ready8}, 64'd0);
    @(posedge clk); #1;
    chk("rst_m_valid", {56'd0, m_valid8}, 64'd0);
    chk("rst_m_data", m_data8, 64'd0);
    chk("rst_rr_ptr", {61'd0, rr_ptr8}, 64'd0);
    chk("rst_err_sel", {63'd0, err_sel8}, 64'd0);
    rst_n = 1'b1;

    // 1. Directed sweep at full throughput
    c0 = cyc;
    stall_sum = 0;
    for (int i = 0; i < 8; i++) begin
      send8(3'(i), 8'hA0 + 8'(i), 1'b0, st);
      stall_sum += st;
      chk("sweep_latency", {56'd0, m_valid8}, 64'd1 << i);
    end
    chk("sweep_stalls", 64'(stall_sum), 64'd0);
    chk("sweep_cycles", 64'(cyc - c0), 64'd8);

    // 2. Backpressure on channel 3, queued beat for channel 6
    m_ready8 = 8'hF7;
    send8(3'd3, 8'h5C, 1'b0, st);
    s_valid8 = 1'b1; s_sel8 = 3'd6; s_data8 = 8'h11; mode8 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_s_ready", {63'd0, s_ready8}, 64'd0);
      chk("bp_m_valid", {56'd0, m_valid8}, 64'h08);
      @(posedge clk); #1;
    end
    m_ready8 = 8'hFF;
    @(negedge clk);
    chk("bp_release_ready", {63'd0, s_ready8}, 64'd1);
    if (s_ready8) q8.push_back('{dst: 3'd6, data: 8'h11});
    @(posedge clk); #1;
    s_valid8 = 1'b0;
    chk("bp_no_bubble", {56'd0, m_valid8}, 64'h40);

    // 3. Round-robin with random s_sel
    for (int i = 0; i < 10; i++) begin
      send8(3'($urandom_range(7, 0)), 8'(i), 1'b1, st);
    end
    chk("rr_ptr_after", {61'd0, rr_ptr8}, 64'd2);
    chk("rr_no_err", {63'd0, err_sel8}, 64'd0);
    repeat (2) @(posedge clk); #1;

    // 5. Reset while a beat is stalled
    m_ready8 = 8'h00;
    send8(3'd4, 8'h77, 1'b0, st);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_s_ready", {63'd0, s_ready8}, 64'd0);
    @(posedge clk); #1;
    q8.delete();
    tb_rr = 3'd0;
    chk("rst_mid_m_valid", {56'd0, m_valid8}, 64'd0);
    chk("rst_mid_m_data", m_data8, 64'd0);
    chk("rst_mid_rr_ptr", {61'd0, rr_ptr8}, 64'd0);
    rst_n = 1'b1;
    m_ready8 = 8'hFF;
    repeat (3) @(posedge clk); #1;

    // 6. Mode switch with a stalled directed beat
    m_ready8 = 8'hFB;
    send8(3'd2, 8'h22, 1'b0, st);
    mode8 = 1'b1;
    repeat (2) @(negedge clk);
    chk("ms_held", {56'd0, m_valid8}, 64'h04);
    @(posedge clk); #1;
    m_ready8 = 8'hFF;
    send8(3'd6, 8'h33, 1'b1, st);
    chk("ms_rr_dst", {56'd0, m_valid8}, 64'h01);
    chk("ms_rr_ptr", {61'd0, rr_ptr8}, 64'd1);
    repeat (3) @(posedge clk); #1;
    chk("q8_drained", 64'(q8.size()), 64'd0);

    // 4. Out-of-range select on the 6-channel instance
    s_valid6 = 1'b1; s_sel6 = 3'd7; s_data6 = 8'hFF;
    @(negedge clk);
    chk("inv_s_ready", {63'd0, s_ready6}, 64'd1);
    @(posedge clk); #1;
    s_valid6 = 1'b0;
    chk("inv_err_pulse", {63'd0, err_sel6}, 64'd1);
    chk("inv_no_valid", {58'd0, m_valid6}, 64'd0);
    s_valid6 = 1'b1; s_sel6 = 3'd5; s_data6 = 8'h55;
    @(negedge clk);
    chk("inv_next_ready", {63'd0, s_ready6}, 64'd1);
    if (s_ready6) q6.push_back('{dst: 3'd5, data: 8'h55});
    @(posedge clk); #1;
    s_valid6 = 1'b0;
    chk("inv_err_clear", {63'd0, err_sel6}, 64'd0);
    chk("inv_next_valid", {58'd0, m_valid6}, 64'h20);
    repeat (3) @(posedge clk); #1;
    chk("q6_drained", 64'(q6.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
